// File: rtl/pf_ddr3_phase_pkg.sv
// Shared types and defaults for the DDR3 CCC PLL phase sequencer.
package pf_ddr3_phase_pkg;

    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_LOCK_WAIT = 4'd1,
        ST_IDLE      = 4'd2,
        ST_SETUP     = 4'd3,
        ST_PULSE     = 4'd4,
        ST_GAP       = 4'd5,
        ST_LOAD      = 4'd6,
        ST_DONE      = 4'd7,
        ST_FAULT     = 4'd8
    } state_e;

    localparam logic [1:0] SEL_OUT0 = 2'd0;
    localparam logic [1:0] SEL_OUT2 = 2'd1;
    localparam logic [1:0] SEL_OUT3 = 2'd2;
    localparam logic [1:0] SEL_ALL  = 2'd3;

    localparam int PULSE_W_DEF      = 2;
    localparam int GAP_W_DEF        = 2;
    localparam int LOCK_TIMEOUT_DEF = 4096;

    // Output select mask: bit0 = OUT0, bit1 = OUT2, bit2 = OUT3.
    function automatic logic [2:0] sel_mask(input logic [1:0] sel);
        logic [2:0] m;
        case (sel)
            SEL_OUT0: m = 3'b001;
            SEL_OUT2: m = 3'b010;
            SEL_OUT3: m = 3'b100;
            SEL_ALL:  m = 3'b111;
            default:  m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/pf_ddr3_lock_mon.sv
// PLL lock synchroniser, fall detector and lock watchdog.
// Watchdog present only with PF_DDR3_PHASE_CTRL_LOCK_WDOG_EN defined.
module pf_ddr3_lock_mon
    import pf_ddr3_phase_pkg::*;
#(
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lock_async,
    input  logic i_timer_en,
    output logic o_lock_sync,
    output logic o_lock_fall,
    output logic o_timeout
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
        end else begin
            r_sync1   <= i_lock_async;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign o_lock_sync = r_sync2;
    assign o_lock_fall = r_sync2_d & ~r_sync2;

`ifdef PF_DDR3_PHASE_CTRL_LOCK_WDOG_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    logic [TW-1:0] r_timer;

    // Counts LOCK_WAIT cycles; held at zero whenever the sequencer is elsewhere.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer <= TW'(0);
        end else if (i_timer_en) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= TW'(0);
        end
    end

    assign o_timeout = i_timer_en && (r_timer == TW'(LOCK_TIMEOUT - 1));
`else
    logic w_unused_wdog;
    assign w_unused_wdog = i_timer_en & (LOCK_TIMEOUT > 0);
    assign o_timeout     = 1'b0;
`endif

endmodule

// File: rtl/pf_ddr3_ccc_phase_ctrl.sv
// PolarFire CCC PLL power-up and phase-shift sequencer for the DDR3 controller.
// Optional lock watchdog / FAULT state: PF_DDR3_PHASE_CTRL_LOCK_WDOG_EN.
module pf_ddr3_ccc_phase_ctrl
    import pf_ddr3_phase_pkg::*;
#(
    parameter int PULSE_W      = PULSE_W_DEF,
    parameter int GAP_W        = GAP_W_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
    parameter int POS_W        = 8
)(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             PLL_EN,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_SEL,
    input  logic             REQ_DIR,
    input  logic [3:0]       REQ_STEPS,
    output logic             DONE,
    output logic             LOCK_LOST,
    output logic             ERR,
    output logic             PLL_READY,
    output logic [POS_W-1:0] POS0,
    output logic [POS_W-1:0] POS2,
    output logic [POS_W-1:0] POS3,
    input  logic             PLL_LOCK_I,
    output logic             PLL_POWERDOWN_N_O,
    output logic             PHASE_OUT0_SEL_O,
    output logic             PHASE_OUT2_SEL_O,
    output logic             PHASE_OUT3_SEL_O,
    output logic             PHASE_DIRECTION_O,
    output logic             PHASE_ROTATE_O,
    output logic             LOAD_PHASE_N_O
);

    localparam int CW = $clog2(((PULSE_W > GAP_W) ? PULSE_W : GAP_W) + 1);

    state_e           r_state, w_nxt_state;
    logic [CW-1:0]    r_cnt, w_nxt_cnt;
    logic [3:0]       r_rem, w_nxt_rem;
    logic [1:0]       r_sel, w_nxt_sel;
    logic             r_dir, w_nxt_dir;
    logic             w_step, w_lost, w_busy, w_clear;
    logic             w_lock_sync, w_lock_fall, w_timeout;
    logic             r_req_ready, r_done, r_lock_lost, r_pll_ready;
    logic             r_pd_n, r_rot, r_load_n, r_dir_o;
    logic [2:0]       r_phsel, w_upd_mask;
    logic [POS_W-1:0] r_pos0, r_pos2, r_pos3, w_delta;

    pf_ddr3_lock_mon #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_lock_mon (
        .i_clk        (CLK),
        .i_rst        (RESET),
        .i_lock_async (PLL_LOCK_I),
        .i_timer_en   (r_state == ST_LOCK_WAIT),
        .o_lock_sync  (w_lock_sync),
        .o_lock_fall  (w_lock_fall),
        .o_timeout    (w_timeout)
    );

    // Next-state, request latching and step bookkeeping.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_rem   = r_rem;
        w_nxt_sel   = r_sel;
        w_nxt_dir   = r_dir;
        w_nxt_cnt   = r_cnt;
        w_step      = 1'b0;
        w_lost      = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (PLL_EN) w_nxt_state = ST_LOCK_WAIT;
                else        w_nxt_state = ST_OFF;
            end
            ST_LOCK_WAIT: begin
                if (w_lock_sync) begin
                    w_nxt_state = ST_IDLE;
                end
`ifdef PF_DDR3_PHASE_CTRL_LOCK_WDOG_EN
                else if (w_timeout) begin
                    w_nxt_state = ST_FAULT;
                end
`endif
                else begin
                    w_nxt_state = ST_LOCK_WAIT;
                end
            end
            ST_IDLE: begin
                if (REQ_VALID) begin
                    w_nxt_sel = REQ_SEL;
                    w_nxt_dir = REQ_DIR;
                    w_nxt_rem = REQ_STEPS;
                    if (REQ_STEPS == 4'd0) w_nxt_state = ST_DONE;
                    else                   w_nxt_state = ST_SETUP;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_SETUP: w_nxt_state = ST_PULSE;
            ST_PULSE: begin
                if (r_cnt == CW'(PULSE_W - 1)) w_nxt_state = ST_GAP;
                else                           w_nxt_state = ST_PULSE;
            end
            ST_GAP: begin
                if (r_cnt == CW'(GAP_W - 1)) begin
                    w_step    = 1'b1;
                    w_nxt_rem = r_rem - 4'd1;
                    if (r_rem == 4'd1) w_nxt_state = ST_LOAD;
                    else               w_nxt_state = ST_PULSE;
                end else begin
                    w_nxt_state = ST_GAP;
                end
            end
            ST_LOAD: begin
                if (r_cnt == CW'(PULSE_W - 1)) w_nxt_state = ST_DONE;
                else                           w_nxt_state = ST_LOAD;
            end
            ST_DONE:  w_nxt_state = ST_IDLE;
            ST_FAULT: w_nxt_state = ST_FAULT;
            default:  w_nxt_state = ST_OFF;
        endcase
        // Power-down beats lock loss; both abandon any in-flight request.
        if (!PLL_EN) begin
            w_nxt_state = ST_OFF;
            w_step      = 1'b0;
        end else if (w_lock_fall && (r_state inside {ST_IDLE, ST_SETUP, ST_PULSE,
                                                     ST_GAP, ST_LOAD, ST_DONE})) begin
            w_nxt_state = ST_LOCK_WAIT;
            w_lost      = 1'b1;
            w_step      = 1'b0;
        end else begin
            w_lost      = 1'b0;
        end
        if (w_nxt_state != r_state) w_nxt_cnt = CW'(0);
        else                        w_nxt_cnt = r_cnt + CW'(1);
    end

    assign w_busy     = w_nxt_state inside {ST_SETUP, ST_PULSE, ST_GAP, ST_LOAD};
    assign w_clear    = (w_nxt_state == ST_OFF) | w_lost;
    assign w_delta    = r_dir ? POS_W'(1'b1) : {POS_W{1'b1}};
    assign w_upd_mask = w_step ? sel_mask(r_sel) : 3'b000;

    // State, request context and outputs registered from the next state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_OFF;
            r_cnt       <= CW'(0);
            r_rem       <= 4'd0;
            r_sel       <= 2'd0;
            r_dir       <= 1'b0;
            r_pd_n      <= 1'b0;
            r_req_ready <= 1'b0;
            r_pll_ready <= 1'b0;
            r_phsel     <= 3'b000;
            r_dir_o     <= 1'b0;
            r_rot       <= 1'b0;
            r_load_n    <= 1'b1;
            r_done      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_rem       <= w_nxt_rem;
            r_sel       <= w_nxt_sel;
            r_dir       <= w_nxt_dir;
            r_pd_n      <= (w_nxt_state != ST_OFF);
            r_req_ready <= (w_nxt_state == ST_IDLE);
            r_pll_ready <= w_busy | (w_nxt_state == ST_IDLE) | (w_nxt_state == ST_DONE);
            r_phsel     <= w_busy ? sel_mask(w_nxt_sel) : 3'b000;
            r_dir_o     <= w_busy & w_nxt_dir;
            r_rot       <= (w_nxt_state == ST_PULSE);
            r_load_n    <= (w_nxt_state != ST_LOAD);
            r_done      <= (w_nxt_state == ST_DONE);
            r_lock_lost <= w_lost;
        end
    end

    // Phase offset trackers; cleared whenever the PLL returns to default phases.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pos0 <= {POS_W{1'b0}};
            r_pos2 <= {POS_W{1'b0}};
            r_pos3 <= {POS_W{1'b0}};
        end else if (w_clear) begin
            r_pos0 <= {POS_W{1'b0}};
            r_pos2 <= {POS_W{1'b0}};
            r_pos3 <= {POS_W{1'b0}};
        end else begin
            if (w_upd_mask[0]) r_pos0 <= r_pos0 + w_delta;
            if (w_upd_mask[1]) r_pos2 <= r_pos2 + w_delta;
            if (w_upd_mask[2]) r_pos3 <= r_pos3 + w_delta;
        end
    end

`ifdef PF_DDR3_PHASE_CTRL_LOCK_WDOG_EN
    logic r_err;

    // Fault flag follows the FAULT state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_err <= 1'b0;
        else       r_err <= (w_nxt_state == ST_FAULT);
    end

    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    assign REQ_READY         = r_req_ready;
    assign DONE              = r_done;
    assign LOCK_LOST         = r_lock_lost;
    assign PLL_READY         = r_pll_ready;
    assign POS0              = r_pos0;
    assign POS2              = r_pos2;
    assign POS3              = r_pos3;
    assign PLL_POWERDOWN_N_O = r_pd_n;
    assign PHASE_OUT0_SEL_O  = r_phsel[0];
    assign PHASE_OUT2_SEL_O  = r_phsel[1];
    assign PHASE_OUT3_SEL_O  = r_phsel[2];
    assign PHASE_DIRECTION_O = r_dir_o;
    assign PHASE_ROTATE_O    = r_rot;
    assign LOAD_PHASE_N_O    = r_load_n;

endmodule

// File: tb/tb_pf_ddr3_ccc_phase_ctrl.sv
// Directed bench for pf_ddr3_ccc_phase_ctrl (PULSE_W=2, GAP_W=2, LOCK_TIMEOUT=16).
module tb_pf_ddr3_ccc_phase_ctrl;

    logic       CLK = 1'b0;
    logic       RESET, PLL_EN, REQ_VALID, REQ_DIR, PLL_LOCK_I;
    logic [1:0] REQ_SEL;
    logic [3:0] REQ_STEPS;
    logic       REQ_READY, DONE, LOCK_LOST, ERR, PLL_READY;
    logic [7:0] POS0, POS2, POS3;
    logic       PD_N, SEL0, SEL2, SEL3, DIR_O, ROT, LOAD_N;

    int checks = 0;
    int errors = 0;
    int n_done;
    logic [31:0] v_rot, v_ldn, v_done, v_sel0, v_sel2, v_sel3, v_dir, v_rdy;

    pf_ddr3_ccc_phase_ctrl #(
        .PULSE_W(2), .GAP_W(2), .LOCK_TIMEOUT(16), .POS_W(8)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PLL_EN(PLL_EN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_SEL(REQ_SEL),
        .REQ_DIR(REQ_DIR), .REQ_STEPS(REQ_STEPS), .DONE(DONE),
        .LOCK_LOST(LOCK_LOST), .ERR(ERR), .PLL_READY(PLL_READY),
        .POS0(POS0), .POS2(POS2), .POS3(POS3), .PLL_LOCK_I(PLL_LOCK_I),
        .PLL_POWERDOWN_N_O(PD_N), .PHASE_OUT0_SEL_O(SEL0),
        .PHASE_OUT2_SEL_O(SEL2), .PHASE_OUT3_SEL_O(SEL3),
        .PHASE_DIRECTION_O(DIR_O), .PHASE_ROTATE_O(ROT), .LOAD_PHASE_N_O(LOAD_N)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int i);
        v_rot[i]  = ROT;
        v_ldn[i]  = LOAD_N;
        v_done[i] = DONE;
        v_sel0[i] = SEL0;
        v_sel2[i] = SEL2;
        v_sel3[i] = SEL3;
        v_dir[i]  = DIR_O;
        v_rdy[i]  = REQ_READY;
    endtask

    // Issue a request in the current (idle) cycle T and record cycles T..T+n.
    task automatic do_req(input logic [1:0] sel, input logic dir, input logic [3:0] steps, input int n);
        {v_rot, v_ldn, v_done, v_sel0, v_sel2, v_sel3, v_dir, v_rdy} = '0;
        REQ_SEL   = sel;
        REQ_DIR   = dir;
        REQ_STEPS = steps;
        REQ_VALID = 1'b1;
        sample(0);
        for (int i = 1; i <= n; i++) begin
            tick();
            REQ_VALID = 1'b0;
            sample(i);
        end
    endtask

    initial begin
        RESET = 1'b1; PLL_EN = 1'b0; REQ_VALID = 1'b0; REQ_DIR = 1'b0;
        PLL_LOCK_I = 1'b0; REQ_SEL = 2'd0; REQ_STEPS = 4'd0;
        tick(); tick();
        chk("rst_pd_n", PD_N, 1'b0);
        chk("rst_load_n", LOAD_N, 1'b1);
        chk("rst_misc", {REQ_READY, DONE, LOCK_LOST, ERR, PLL_READY, SEL0, SEL2, SEL3, DIR_O, ROT}, 32'h0);
        chk("rst_pos", {POS0, POS2, POS3}, 32'h0);
        RESET = 1'b0;
        tick();
        chk("off_pd_n", PD_N, 1'b0);

        // Lock never arrives: watchdog after 16 LOCK_WAIT cycles when present.
        PLL_EN = 1'b1;
        tick();
        chk("lw_pd_n", PD_N, 1'b1);
        chk("lw_ready", PLL_READY, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk("wdog_err_early", ERR, 1'b0);
        tick();
`ifdef PF_DDR3_PHASE_CTRL_LOCK_WDOG_EN
        chk("wdog_err", ERR, 1'b1);
`else
        chk("wdog_err", ERR, 1'b0);
`endif
        chk("wdog_pd_n", PD_N, 1'b1);
        PLL_EN = 1'b0;
        tick();
        chk("off_err", ERR, 1'b0);
        chk("off_pd_n2", PD_N, 1'b0);

        // Power up and lock: PLL_READY three cycles after lock rises.
        PLL_EN = 1'b1;
        tick();
        chk("up_pd_n", PD_N, 1'b1);
        PLL_LOCK_I = 1'b1;
        tick(); tick();
        chk("lock_c2", PLL_READY, 1'b0);
        tick();
        chk("lock_c3", PLL_READY, 1'b1);
        chk("lock_req_ready", REQ_READY, 1'b1);

        // All outputs, retard by one step.
        do_req(2'd3, 1'b0, 4'd1, 9);
        chk("all_rot", v_rot, 32'h0C);
        chk("all_ldn", v_ldn, 32'h33F);
        chk("all_done", v_done, 32'h100);
        chk("all_sel0", v_sel0, 32'hFE);
        chk("all_sel2", v_sel2, 32'hFE);
        chk("all_sel3", v_sel3, 32'hFE);
        chk("all_dir", v_dir, 32'h0);
        chk("all_pos", {POS0, POS2, POS3}, 32'hFFFFFF);

        // Zero steps: immediate DONE, no rotation.
        do_req(2'd0, 1'b1, 4'd0, 2);
        chk("z_done", v_done, 32'h2);
        chk("z_rot", v_rot, 32'h0);
        chk("z_sel0", v_sel0, 32'h0);
        chk("z_ldn", v_ldn, 32'h7);
        chk("z_rdy", v_rdy, 32'h5);
        chk("z_pos", {POS0, POS2, POS3}, 32'hFFFFFF);

        // Power-cycle clears positions, then relock.
        PLL_EN = 1'b0;
        tick();
        chk("pc_pos", {POS0, POS2, POS3}, 32'h0);
        chk("pc_pd_n", PD_N, 1'b0);
        chk("pc_ready", PLL_READY, 1'b0);
        PLL_EN = 1'b1;
        for (int i = 0; i < 10 && !PLL_READY; i++) tick();
        chk("pc_relock", PLL_READY, 1'b1);

        // OUT0 advance by three steps.
        do_req(2'd0, 1'b1, 4'd3, 17);
        chk("adv_rot", v_rot, 32'hCCC);
        chk("adv_ldn", v_ldn, 32'h33FFF);
        chk("adv_done", v_done, 32'h10000);
        chk("adv_sel0", v_sel0, 32'hFFFE);
        chk("adv_dir", v_dir, 32'hFFFE);
        chk("adv_sel23", v_sel2 | v_sel3, 32'h0);
        chk("adv_rdy", v_rdy, 32'h20001);
        chk("adv_pos", {POS0, POS2, POS3}, 32'h030000);

        // Lock drops during the second pulse of an OUT2 request.
        REQ_SEL = 2'd1; REQ_DIR = 1'b1; REQ_STEPS = 4'd3; REQ_VALID = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("ll_pos2_pre", POS2, 8'h01);
        chk("ll_rot_pre", ROT, 1'b1);
        PLL_LOCK_I = 1'b0;
        tick();
        chk("ll_lost_t7", LOCK_LOST, 1'b0);
        tick();
        chk("ll_lost_t8", LOCK_LOST, 1'b0);
        tick();
        chk("ll_lost", LOCK_LOST, 1'b1);
        chk("ll_rot", ROT, 1'b0);
        chk("ll_pos", {POS0, POS2, POS3}, 32'h0);
        chk("ll_ctl", {SEL0, SEL2, SEL3, DIR_O, LOAD_N}, 32'h1);
        chk("ll_ready", {PLL_READY, REQ_READY, PD_N}, 32'h1);
        tick();
        chk("ll_lost_pulse", LOCK_LOST, 1'b0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (DONE) n_done++;
            tick();
        end
        chk("ll_no_done", n_done, 0);

        // Asynchronous reset between clock edges.
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_pd_n", PD_N, 1'b0);
        chk("arst_err", ERR, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pf_ddr3_ccc_phase_ctrl.md
# pf_ddr3_ccc_phase_ctrl

Sequencer for the DDR3 controller's PolarFire CCC PLL. It drives the PLL power-down release, waits for lock, then accepts phase-shift requests from the DDR training logic. Each request becomes the exact PHASE_*_SEL / PHASE_DIRECTION / PHASE_ROTATE / LOAD_PHASE_N pulse train for OUT0, OUT2 and OUT3. The block sits between the training FSM and the CCC instance, in the CCC's reference-clock-derived fabric domain, and tracks the accumulated phase offset of each output.

## Interface
- PULSE_W, 2: cycles PHASE_ROTATE / LOAD_PHASE_N are held active; must be ≥1.
- GAP_W, 2: idle cycles after each rotate pulse; must be ≥1.
- LOCK_TIMEOUT, 4096: LOCK_WAIT cycles before FAULT; must be ≥1.
- POS_W, 8: width of each position counter.
- CLK  in  1  block clock; all logic is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PLL_EN  in  1  level; 1 = power up the PLL and keep it running.
- REQ_VALID  in  1  phase request valid.
- REQ_READY  out  1  request accepted when VALID & READY.
- REQ_SEL  in  2  target output: 0 = OUT0, 1 = OUT2, 2 = OUT3, 3 = all three.
- REQ_DIR  in  1  1 = advance, 0 = retard.
- REQ_STEPS  in  4  number of rotate steps, 0–15.
- DONE  out  1  one-cycle pulse when a request completes.
- LOCK_LOST  out  1  one-cycle pulse when lock drops after PLL_READY.
- ERR  out  1  level; high in FAULT.
- PLL_READY  out  1  high in IDLE and in all request states.
- POS0, POS2, POS3  out  POS_W each  accumulated offset per output, two's complement.
- PLL_LOCK_I  in  1  PLL LOCK; asynchronous to CLK.
- PLL_POWERDOWN_N_O, PHASE_OUT0_SEL_O, PHASE_OUT2_SEL_O, PHASE_OUT3_SEL_O, PHASE_DIRECTION_O, PHASE_ROTATE_O, LOAD_PHASE_N_O  out  1 each  PLL phase and power controls.

## Operation
- States: OFF, LOCK_WAIT, IDLE, SETUP, PULSE, GAP, LOAD, DONE_ST, FAULT.
- All outputs are registered.
- Reset values:
  - PLL_POWERDOWN_N_O = 0 and LOAD_PHASE_N_O = 1.
  - All other outputs = 0, including POS0/POS2/POS3.
  - State = OFF.
- OFF:
  - PLL_POWERDOWN_N_O = 0 and all positions cleared.
  - PLL_EN = 1 → LOCK_WAIT.
- LOCK_WAIT:
  - PLL_POWERDOWN_N_O = 1 and the timer runs.
  - Synchronised lock = 1 → IDLE.
  - Timer reaches LOCK_TIMEOUT → FAULT.
- FAULT: ERR = 1 and the PLL stays powered; PLL_EN = 0 → OFF.
- IDLE:
  - REQ_READY = 1.
  - On accept, REQ_SEL, REQ_DIR and REQ_STEPS are latched.
  - REQ_STEPS = 0 → DONE_ST; otherwise → SETUP.
- SETUP (1 cycle):
  - The selected PHASE_OUTx_SEL_O are driven to 1; REQ_SEL = 3 drives all three.
  - PHASE_DIRECTION_O = latched REQ_DIR.
  - Selects and direction are held unchanged through LOAD.
- PULSE: PHASE_ROTATE_O = 1 for PULSE_W cycles → GAP.
- GAP:
  - PHASE_ROTATE_O = 0 for GAP_W cycles.
  - On the last GAP cycle, each selected POS is incremented by 1 (advance) or decremented by 1 (retard), wrapping modulo 2^POS_W, and the remaining-step count is decremented.
  - Remaining > 0 → PULSE; otherwise → LOAD.
- LOAD: LOAD_PHASE_N_O = 0 for PULSE_W cycles → DONE_ST.
- DONE_ST (1 cycle): DONE = 1, selects and direction = 0 → IDLE.
- Lock loss: synchronised lock falling in any of IDLE..DONE_ST:
  - Pulse LOCK_LOST and go to LOCK_WAIT with the timer restarted.
  - Clear ROTATE, all selects and direction; LOAD_PHASE_N_O = 1.
  - Clear all POS counters (the PLL relocks to its default phases).
  - The in-flight request is dropped and no DONE is issued.
- PLL_EN = 0 in any state: next state is OFF, with the same output clearing as lock loss and no LOCK_LOST pulse. PLL_EN = 0 takes priority over lock loss.
- Reset mid-operation: asynchronous return to the reset values.

## Timing
- PLL_LOCK_I uses a 2-flop synchroniser.
- Lock timing: PLL_LOCK_I rises at C → IDLE and PLL_READY = 1 at C+3.
- Request timing (request accepted at cycle T):
  - SETUP at T+1.
  - First PHASE_ROTATE_O high over T+2 .. T+1+PULSE_W.
  - Each step lasts PULSE_W+GAP_W cycles.
  - DONE at T+2+N·(PULSE_W+GAP_W)+PULSE_W.
  - REQ_STEPS = 0 → DONE at T+1.
- REQ_READY returns to 1 on the cycle after DONE, so back-to-back requests are spaced by at least 1 idle cycle.
- POS updates are visible on the cycle after the last GAP cycle of each step.

## Configuration
- PF_DDR3_PHASE_CTRL_LOCK_WDOG_EN:
  - Defined: LOCK_WAIT timeout and the FAULT state are present, as described above.
  - Undefined: LOCK_WAIT waits indefinitely, FAULT is unreachable, ERR is tied to 0, and the timer logic is removed.

## Structure
- Package pf_ddr3_phase_pkg:
  - State enum.
  - REQ_SEL encodings (SEL_OUT0, SEL_OUT2, SEL_OUT3, SEL_ALL).
  - Default constants for PULSE_W, GAP_W and LOCK_TIMEOUT.
- Sub-module pf_ddr3_lock_mon:
  - Contains the 2-flop synchroniser, fall detect and the watchdog counter.
  - Outputs lock_sync, lock_fall and timeout.

## Test plan
- Reset, then PLL_EN = 1, then PLL_LOCK_I = 1 at C → PLL_POWERDOWN_N_O = 1 from the cycle after PLL_EN; PLL_READY = 1 at C+3.
- Defaults, request SEL = 0, DIR = 1, STEPS = 3 accepted at T:
  - 3 ROTATE pulses, 2 cycles each, with 2-cycle gaps.
  - LOAD_PHASE_N_O low for 2 cycles.
  - DONE at T+16; POS0 = 3; POS2 = POS3 = 0.
- SEL = 3, DIR = 0, STEPS = 1 starting from all-zero positions → all three selects high during the sequence; POS0 = POS2 = POS3 = 0xFF.
- STEPS = 0 → DONE at T+1, no ROTATE pulse, positions unchanged.
- PLL_LOCK_I drops during the 2nd PULSE → LOCK_LOST pulse, ROTATE = 0 the next cycle, no DONE, POS cleared, state LOCK_WAIT.
- Macro defined, LOCK_TIMEOUT = 16, lock never asserts → ERR = 1 after 16 LOCK_WAIT cycles; PLL_EN = 0 → OFF with ERR = 0.
